// File: rtl/dsp_arbiter_pkg.sv
// dsp_arbiter_pkg: shared DSP48A1 bundle layout, opmode codes and default latency.
package dsp_arbiter_pkg;

    localparam int DSP_INS_W = 92;
    localparam int DSP_OUT_W = 48;
    localparam int DSP_LAT   = 3;

    localparam int C_LSB      = 0;
    localparam int B_LSB      = 48;
    localparam int A_LSB      = 66;
    localparam int OPMODE_LSB = 84;

    localparam logic [7:0] DSP_NOP     = 8'h00;
    localparam logic [7:0] DSP_OP_MULT = 8'h01;
    localparam logic [7:0] DSP_OP_MADD = 8'h0d;

    typedef struct packed {
        logic [7:0]  opmode;
        logic [17:0] a;
        logic [17:0] b;
        logic [47:0] c;
    } dsp_ins_t;

    localparam dsp_ins_t DSP_NOP_INS = '{opmode: DSP_NOP, a: '0, b: '0, c: '0};

endpackage

// File: rtl/dsp_arb_rr_pick.sv
// dsp_arb_rr_pick: combinational round-robin picker, first set request at or after the pointer.
module dsp_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_rr_ptr,
    output logic [NREQ-1:0] o_pick,
    output logic [PW-1:0]   o_pick_idx,
    output logic            o_valid
);

    // Scanning from the far end lets the nearest requester overwrite the result last.
    always_comb begin
        int j;
        j          = 0;
        o_pick     = '0;
        o_pick_idx = '0;
        o_valid    = |i_req;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(i_rr_ptr) + i;
            j = (j >= NREQ) ? j - NREQ : j;
            if (i_req[j]) begin
                o_pick     = '0;
                o_pick[j]  = 1'b1;
                o_pick_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/dsp_arbiter.sv
// dsp_arbiter: round-robin burst arbiter sharing one DSP48A1 slice, with owner-tagged results.
// Define DSP_ARB_TIMEOUT_EN to add MAX_HOLD preemption and the preempt output.
module dsp_arbiter
    import dsp_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DSP_LAT = dsp_arbiter_pkg::DSP_LAT
`ifdef DSP_ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 32
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    output logic [NREQ-1:0]           gnt,
    input  logic [NREQ*DSP_INS_W-1:0] req_ins_flat,
    output logic [DSP_INS_W-1:0]      dsp_ins_flat,
    input  logic [DSP_OUT_W-1:0]      dsp_outs_flat,
    output logic [DSP_OUT_W-1:0]      p,
`ifdef DSP_ARB_TIMEOUT_EN
    output logic [NREQ-1:0]           preempt,
`endif
    output logic [NREQ-1:0]           p_owner
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] r_gnt;
    logic [PW-1:0]   r_rr_ptr;
    logic [NREQ-1:0] r_tag [DSP_LAT];
    logic [NREQ-1:0] w_sel;
    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_pick;
    logic [PW-1:0]   w_pick_idx;
    logic            w_valid;
    logic            w_keep;
    logic            w_new;
    dsp_ins_t        w_ins;

    assign w_sel  = r_gnt & req;
    // The current owner is never a candidate: a releasing owner re-queues behind others.
    assign w_cand = req & ~r_gnt;

    dsp_arb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .i_req      (w_cand),
        .i_rr_ptr   (r_rr_ptr),
        .o_pick     (w_pick),
        .o_pick_idx (w_pick_idx),
        .o_valid    (w_valid)
    );

`ifdef DSP_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0]   r_hold;
    logic [NREQ-1:0] r_preempt;
    logic            w_expire;
    logic            w_force;

    assign w_expire = (int'(r_hold) + 1 >= MAX_HOLD);
    assign w_force  = (|w_sel) & w_expire & w_valid;
    assign w_keep   = (|w_sel) & ~w_force;
    assign preempt  = r_preempt;

    // Hold saturates while nobody else is waiting, so preemption fires as soon as someone arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold    <= '0;
            r_preempt <= '0;
        end else begin
            r_hold    <= !w_keep ? '0 : (w_expire ? r_hold : r_hold + 1'b1);
            r_preempt <= w_force ? r_gnt : '0;
        end
    end
`else
    assign w_keep = |w_sel;
`endif

    assign w_new = ~w_keep & w_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_gnt <= w_keep ? r_gnt : w_pick;
            if (w_new)
                r_rr_ptr <= (w_pick_idx == PW'(NREQ - 1)) ? '0 : PW'(w_pick_idx + 1'b1);
        end
    end

    always_comb begin
        w_ins = DSP_NOP_INS;
        for (int k = 0; k < NREQ; k++)
            if (w_sel[k])
                w_ins = req_ins_flat[k*DSP_INS_W +: DSP_INS_W];
    end

    assign dsp_ins_flat = w_ins;

    // The tag travels alongside the op so results stay attributed after ownership moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DSP_LAT; i++)
                r_tag[i] <= '0;
        end else begin
            r_tag[0] <= (dsp_ins_flat[OPMODE_LSB +: 8] != DSP_NOP) ? w_sel : '0;
            for (int i = 1; i < DSP_LAT; i++)
                r_tag[i] <= r_tag[i-1];
        end
    end

    assign gnt     = r_gnt;
    assign p       = dsp_outs_flat;
    assign p_owner = r_tag[DSP_LAT-1];

endmodule

// File: tb/tb_dsp_arbiter.sv
// tb_dsp_arbiter: directed self-checking bench for dsp_arbiter with a 3-stage DSP slice model.
module tb_dsp_arbiter;
    import dsp_arbiter_pkg::*;

    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      gnt;
    logic [91:0]          bun [NREQ];
    logic [NREQ*92-1:0]   req_ins_flat;
    logic [91:0]          dsp_ins_flat;
    logic [47:0]          dsp_outs_flat;
    logic [47:0]          p;
    logic [NREQ-1:0]      p_owner;
    logic [47:0]          m_pipe [3];
`ifdef DSP_ARB_TIMEOUT_EN
    logic [NREQ-1:0]      preempt;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dsp_arbiter #(
        .NREQ(NREQ), .DSP_LAT(3)
`ifdef DSP_ARB_TIMEOUT_EN
        , .MAX_HOLD(8)
`endif
    ) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt),
        .req_ins_flat(req_ins_flat), .dsp_ins_flat(dsp_ins_flat),
        .dsp_outs_flat(dsp_outs_flat), .p(p),
`ifdef DSP_ARB_TIMEOUT_EN
        .preempt(preempt),
`endif
        .p_owner(p_owner)
    );

    always_comb begin
        req_ins_flat = '0;
        for (int k = 0; k < NREQ; k++)
            req_ins_flat[k*92 +: 92] = bun[k];
    end

    // Slice model: p = a*b + c for any non-NOP op, three registered stages later.
    always @(posedge clk) begin
        m_pipe[0] <= (dsp_ins_flat[OPMODE_LSB +: 8] != DSP_NOP) ?
                     48'(dsp_ins_flat[A_LSB +: 18]) * 48'(dsp_ins_flat[B_LSB +: 18]) + dsp_ins_flat[C_LSB +: 48] : 48'd0;
        m_pipe[1] <= m_pipe[0];
        m_pipe[2] <= m_pipe[1];
    end
    assign dsp_outs_flat = m_pipe[2];

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            tests++;
            if (!$onehot0(gnt)) begin
                fails++;
                $display("FAIL onehot: gnt=%b, required one-hot or zero", gnt);
            end
        end
    end

    function automatic logic [91:0] mk(input logic [7:0] op, input logic [17:0] a, input logic [17:0] b, input logic [47:0] c);
        logic [91:0] v;
        v = '0;
        v[OPMODE_LSB +: 8] = op;
        v[A_LSB +: 18]     = a;
        v[B_LSB +: 18]     = b;
        v[C_LSB +: 48]     = c;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        for (int k = 0; k < NREQ; k++) bun[k] = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        for (int k = 0; k < NREQ; k++) bun[k] = '0;
        tick();
        tick();
        #1;
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b, want 0000", gnt); end
        tests++; if (p_owner !== 4'b0000) begin fails++; $display("FAIL reset_p_owner: got %b, want 0000", p_owner); end
        tests++; if (dsp_ins_flat !== 92'd0) begin fails++; $display("FAIL reset_ins: got %h, want 0", dsp_ins_flat); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [91:0] op;
        do_reset();
        req = 4'b0010;
        tick();
        #1;
        tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL single_gnt: got %b, want 0010", gnt); end
        tick();
        op = mk(DSP_OP_MULT, 18'h10000, 18'h08000, 48'd0);
        bun[1] = op;
        #1;
        tests++; if (dsp_ins_flat !== op) begin fails++; $display("FAIL single_ins: got %h, want %h", dsp_ins_flat, op); end
        tick();
        bun[1] = '0;
        tick();
        #1;
        tests++; if (p_owner !== 4'b0000) begin fails++; $display("FAIL single_early_tag: got %b, want 0000", p_owner); end
        tick();
        #1;
        tests++; if (p_owner !== 4'b0010) begin fails++; $display("FAIL single_tag: got %b, want 0010", p_owner); end
        tests++; if (p !== 48'h0000_8000_0000) begin fails++; $display("FAIL single_p: got %h, want 000080000000", p); end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_contention();
        logic [3:0] rq [7] = '{4'b1011, 4'b1011, 4'b1011, 4'b1010, 4'b1000, 4'b0000, 4'b0000};
        logic [3:0] eg [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1000, 4'b0000};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            req = rq[c];
            #1;
            tests++; if (gnt !== eg[c]) begin fails++; $display("FAIL contention_gnt c%0d: got %b, want %b", c, gnt, eg[c]); end
            if (c == 3) begin
                tests++; if (dsp_ins_flat !== 92'd0) begin fails++; $display("FAIL contention_bubble: got %h, want 0", dsp_ins_flat); end
            end
            tick();
        end
    endtask

    task automatic test_handover();
        logic [3:0]  rq [10] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0]  eg [10] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0]  eo [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
        logic [47:0] ep [10] = '{48'd0, 48'd0, 48'd0, 48'd0, 48'd15, 48'd78, 48'h7fffe, 48'd0, 48'd10005, 48'd0};
        logic [17:0] a0 [10] = '{18'd0, 18'd3, 18'd7, 18'h3ffff, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0};
        logic [17:0] b0 [10] = '{18'd0, 18'd5, 18'd11, 18'd2, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0};
        logic [47:0] c0 [10] = '{48'd0, 48'd0, 48'd1, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req    = rq[c];
            bun[0] = (c >= 1 && c <= 3) ? mk(DSP_OP_MULT, a0[c], b0[c], c0[c]) : 92'd0;
            bun[2] = (c == 4 || c == 5) ? mk(DSP_OP_MADD, 18'd100, 18'd100, 48'd5) : 92'd0;
            #1;
            tests++; if (gnt !== eg[c]) begin fails++; $display("FAIL handover_gnt c%0d: got %b, want %b", c, gnt, eg[c]); end
            tests++; if (p_owner !== eo[c]) begin fails++; $display("FAIL handover_tag c%0d: got %b, want %b", c, p_owner, eo[c]); end
            if (eo[c] != 4'b0000) begin
                tests++; if (p !== ep[c]) begin fails++; $display("FAIL handover_p c%0d: got %h, want %h", c, p, ep[c]); end
            end
            if (c == 4) begin
                tests++; if (dsp_ins_flat !== 92'd0) begin fails++; $display("FAIL handover_nonowner: got %h, want 0", dsp_ins_flat); end
            end
            tick();
        end
    endtask

    task automatic test_idle();
        logic [91:0] own;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bun[1] = mk(DSP_OP_MADD, 18'(i * 7 + 1), 18'(i + 3), 48'(i * 11 + 2));
            #1;
            tests++; if (dsp_ins_flat !== 92'd0) begin fails++; $display("FAIL idle_ins i%0d: got %h, want 0", i, dsp_ins_flat); end
            tests++; if (p_owner !== 4'b0000) begin fails++; $display("FAIL idle_tag i%0d: got %b, want 0000", i, p_owner); end
            tick();
        end
        req = 4'b0100;
        own = mk(DSP_OP_MULT, 18'd9, 18'd9, 48'd0);
        bun[2] = own;
        tick();
        for (int i = 0; i < 3; i++) begin
            bun[1] = mk(DSP_OP_MULT, 18'(i + 40), 18'(i + 50), 48'(i));
            #1;
            tests++; if (dsp_ins_flat !== own) begin fails++; $display("FAIL nonowner_toggle i%0d: got %h, want %h", i, dsp_ins_flat, own); end
            tick();
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        tick();
        #1;
        tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL midreset_pre_gnt: got %b, want 0100", gnt); end
        bun[2] = mk(DSP_OP_MULT, 18'd2, 18'd3, 48'd0);
        tick();
        bun[2] = mk(DSP_OP_MULT, 18'd4, 18'd5, 48'd0);
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        req    = 4'b1001;
        bun[2] = '0;
        #1;
        tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL midreset_gnt: got %b, want 0000", gnt); end
        tests++; if (p_owner !== 4'b0000) begin fails++; $display("FAIL midreset_tag: got %b, want 0000", p_owner); end
        tick();
        #1;
        tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL midreset_regrant: got %b, want 0001", gnt); end
        tests++; if (p_owner !== 4'b0000) begin fails++; $display("FAIL midreset_flush1: got %b, want 0000", p_owner); end
        tick();
        #1;
        tests++; if (p_owner !== 4'b0000) begin fails++; $display("FAIL midreset_flush2: got %b, want 0000", p_owner); end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] rq [5] = '{4'b0111, 4'b0110, 4'b0101, 4'b0001, 4'b0000};
        logic [3:0] eg [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0001};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req = rq[c];
            #1;
            tests++; if (gnt !== eg[c]) begin fails++; $display("FAIL requeue_gnt c%0d: got %b, want %b", c, gnt, eg[c]); end
            tick();
        end
        tick();
    endtask

`ifdef DSP_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] eg;
        logic [3:0] ep;
        do_reset();
        req = 4'b0001;
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (c == 3) req = 4'b0101;
            eg = (c < 9) ? 4'b0001 : 4'b0100;
            ep = (c == 9) ? 4'b0001 : 4'b0000;
            #1;
            tests++; if (gnt !== eg) begin fails++; $display("FAIL timeout_gnt c%0d: got %b, want %b", c, gnt, eg); end
            tests++; if (preempt !== ep) begin fails++; $display("FAIL timeout_preempt c%0d: got %b, want %b", c, preempt, ep); end
            tick();
        end
        req = '0;
        tick();
        tick();
    endtask
`endif

    initial begin
        for (int k = 0; k < NREQ; k++) bun[k] = '0;
        test_reset();
        test_single();
        test_contention();
        test_handover();
        test_idle();
        test_reset_mid();
        test_back_to_back();
`ifdef DSP_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
